// File: rtl/alu_inst_encoder.sv
// ALUop-to-RV32I OP/OP-IMM instruction encoder with valid/ready request port,
// a small output FIFO, and saturating emit/illegal statistics counters.
module alu_inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_aluop,
    input  logic             req_use_imm,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [11:0]      req_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic             inst_illegal,
    output logic [CNT_W-1:0] emit_count,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;

    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]  w_funct3;
    logic        w_bit30;
    logic        w_known;
    logic        w_is_shift;
    logic        w_illegal;
    logic [31:0] w_enc;

    always_comb begin
        w_funct3   = 3'b000;
        w_bit30    = 1'b0;
        w_known    = 1'b1;
        w_is_shift = 1'b0;
        case (req_aluop)
            ALU_ADD:  w_funct3 = 3'b000;
            ALU_SUB:  w_bit30  = 1'b1;
            ALU_SLL:  begin w_funct3 = 3'b001; w_is_shift = 1'b1; end
            ALU_SLT:  w_funct3 = 3'b010;
            ALU_SLTU: w_funct3 = 3'b011;
            ALU_XOR:  w_funct3 = 3'b100;
            ALU_SRL:  begin w_funct3 = 3'b101; w_is_shift = 1'b1; end
            ALU_SRA:  begin w_funct3 = 3'b101; w_is_shift = 1'b1; w_bit30 = 1'b1; end
            ALU_OR:   w_funct3 = 3'b110;
            ALU_AND:  w_funct3 = 3'b111;
            default:  w_known  = 1'b0;
        endcase

        // There is no SUBI, and shift immediates only carry a 5-bit shamt.
        w_illegal = !w_known
                 || (req_use_imm && (req_aluop == ALU_SUB))
                 || (req_use_imm && w_is_shift && (|req_imm[11:5]));

        if (w_illegal)
            w_enc = NOP;
        else if (!req_use_imm)
            w_enc = {1'b0, w_bit30, 5'b00000, req_rs2, req_rs1, w_funct3, req_rd, OPC_OP};
        else if (w_is_shift)
            w_enc = {1'b0, w_bit30, 5'b00000, req_imm[4:0], req_rs1, w_funct3, req_rd, OPC_OPIMM};
        else
            w_enc = {req_imm, req_rs1, w_funct3, req_rd, OPC_OPIMM};
    end

    logic [31:0]      r_mem_inst [DEPTH];
    logic             r_mem_ill  [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_emit_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full       = (r_count == FULL_CNT);
    assign req_ready    = !w_full && !flush;
    assign inst_valid   = (r_count != '0);
    assign w_push       = req_valid && req_ready;
    assign w_pop        = inst_valid && inst_ready;
    // Gate storage with valid so the head reads zero out of reset.
    assign inst         = inst_valid ? r_mem_inst[r_head] : 32'h0;
    assign inst_illegal = inst_valid ? r_mem_ill[r_head]  : 1'b0;
    assign emit_count    = r_emit_cnt;
    assign illegal_count = r_ill_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_tail] <= w_enc;
            r_mem_ill[r_tail]  <= w_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_emit_cnt <= '0;
            r_ill_cnt  <= '0;
        end else begin
            if (w_pop)
                r_emit_cnt <= sat_inc(r_emit_cnt);
            if (w_push && w_illegal)
                r_ill_cnt <= sat_inc(r_ill_cnt);

            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_tail <= r_tail + AW'(1);
                if (w_pop)
                    r_head <= r_head + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: doc/alu_inst_encoder.md
# alu_inst_encoder

Encodes ALU operations (ALUop codes from ALUop.vh plus register/immediate operands) into RV32I OP / OP-IMM instruction words: the inverse of the ALU decoder's opcode/funct3/add_rshift_type-to-ALUop mapping. It sits in the instruction-injection path used by the BIST sequencer and the core testbench. Requests are accepted on a valid/ready port, encoded, buffered in a small FIFO, and emitted on a second valid/ready port. Illegal requests are flagged and counted.

## Interface
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 16: width of the saturating statistics counters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears FIFO, counters, outputs.
- flush  in  1  synchronous; empties the FIFO.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at the rising edge.
- req_aluop  in  4  ALUop code (ALUop.vh encoding).
- req_use_imm  in  1  1: OP-IMM (0010011); 0: OP (0110011).
- req_rd, req_rs1, req_rs2  in  5 each  register indices; rs2 ignored when req_use_imm=1.
- req_imm  in  12  I-type immediate; for shifts, only [4:0] is the shamt.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  consumer takes the head when inst_valid && inst_ready.
- inst  out  32  encoded instruction at the FIFO head.
- inst_illegal  out  1  head entry was an illegal request.
- emit_count  out  CNT_W  instructions popped, saturating.
- illegal_count  out  CNT_W  illegal requests accepted, saturating.

## Operation
- funct3 mapping: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- Bit 30 (funct7[5], the add_rshift_type bit) is 1 only for SUB (register form) and SRA (both forms). All other funct7 bits are 0.
- R-type word: {funct7, rs2, rs1, funct3, rd, 0110011}.
- I-type word: {imm[11:0], rs1, funct3, rd, 0010011}.
- I-type shifts: imm field = {0, bit30, 00000, imm[4:0]}.
- Illegal cases:
  - ALUop is not one of the ten codes above (includes ALU_XXX and ALU_COPY_B).
  - SUB with req_use_imm=1.
  - Immediate shift with req_imm[11:5] != 0.
- An illegal request is still accepted and enqueued, with inst = 32'h0000_0013 (NOP) and inst_illegal = 1.
- Encoding is combinational on the request. The result is written into the FIFO tail on acceptance.
- req_ready = !full && !flush. There is no combinational path from inst_ready to req_ready.
- Push and pop may occur in the same cycle when the FIFO is neither empty nor full; occupancy is unchanged.
- Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate log2(DEPTH)+1-bit count.
- flush, sampled at the rising edge:
  - Sets occupancy to 0 and resets both pointers.
  - Blocks push that cycle (req_ready is low).
  - A pop that cycle is still counted if inst_valid && inst_ready was high.
- emit_count increments on each pop. illegal_count increments on each accepted illegal request. Both hold at 2^CNT_W−1.

## Timing
- Reset values: inst_valid=0, inst=0, inst_illegal=0, req_ready=1, both counters 0, pointers and occupancy 0. Assertion takes effect immediately, without waiting for a clock edge.
- Latency: a request accepted at edge N into an empty FIFO gives inst_valid=1 and the encoded word from just after edge N.
- inst and inst_illegal are driven from FIFO storage at the head pointer. They stay stable while inst_valid && !inst_ready.
- Throughput: 1 instruction/cycle when inst_ready is held high.
- Full (occupancy = DEPTH): req_ready=0. A pop frees one slot; req_ready rises the following cycle.
- Empty: inst_valid=0. The inst value is don't-care, but the bench checks it only while inst_valid=1.
- Reset asserted mid-stream: all entries are lost and no pop is counted. req_ready returns to 1 while reset is held.

## Test plan
- ADD, use_imm=0, rd=3, rs1=1, rs2=2, inst_ready=1 → inst_valid one cycle later, inst=0x002081B3, inst_illegal=0, emit_count=1.
- SUB, same registers → 0x402081B3. Then ADD, use_imm=1, rd=5, rs1=0, imm=0xFFF → 0xFFF00293.
- SRA, use_imm=1, rd=1, rs1=1, imm=0x005 → 0x4050D093. Same request with imm=0x025 → 0x00000013, inst_illegal=1, illegal_count=1.
- Backpressure with DEPTH=2, inst_ready=0, three back-to-back requests:
  - The first two are accepted and the third stalls with req_ready=0.
  - Raise inst_ready: the words are emitted in order, the third is accepted the cycle after the first pop, and emit_count=3.
- flush with 2 entries queued and req_valid=1 → inst_valid=0 next cycle, the request is not accepted that cycle and is accepted the following cycle.
- reset asserted between clock edges with 1 entry queued → inst_valid drops immediately and counters read 0. ALU_XXX after release → NOP with inst_illegal=1.
